root_stream_serializer: RTL and testbench

Downstream of `Helios_single_FPGA`: on each rising edge of `result_valid` it snapshots the flat `roots` vector plus `cycle_counter` and `iteration_counter`. It then streams one framed sequence of 32-bit words over a valid/ready interface toward the host link or result FIFO. The frame is a 3-word header followed by one word per processing unit, in decoder index order, using the team's root-word format (z in [23:16], x in [15:8], y in [7:0]). Throughput is one word per cycle when `out_ready` is held high.

---
 rtl/root_stream_serializer.sv | 136 +++++++++++++
 tb/tb_root_stream_serializer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/root_stream_serializer.sv
// rtl/root_stream_serializer.sv - snapshots decoder roots on a result edge and streams them as a framed 32-bit word sequence
module root_stream_serializer #(
  parameter  int CODE_DISTANCE_X         = 5,
  parameter  int CODE_DISTANCE_Z         = 4,
  parameter  int ITERATION_COUNTER_WIDTH = 8,
  localparam int MEASUREMENT_ROUNDS      = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z,
  localparam int PU_COUNT                = CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS,
  localparam int PER_DIM_WIDTH           = $clog2(MEASUREMENT_ROUNDS),
  localparam int ADDRESS_WIDTH           = 3 * PER_DIM_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  result_valid,
  input  logic [ADDRESS_WIDTH*PU_COUNT-1:0]     roots,
  input  logic [31:0]                           cycle_counter,
  input  logic [ITERATION_COUNTER_WIDTH-1:0]    iteration_counter,
  output logic [31:0]                           out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  out_last,
  output logic                                  busy,
  output logic                                  overrun
);

  localparam int                IDX_WIDTH = (PU_COUNT > 1) ? $clog2(PU_COUNT) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(PU_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_HDR2,
    S_BODY
  } state_t;

  state_t                            state, state_next;
  logic [IDX_WIDTH-1:0]              idx, idx_next;
  logic                              valid_d;
  logic [31:0]                       frame_id;
  logic [ADDRESS_WIDTH*PU_COUNT-1:0] shadow_roots;
  logic [31:0]                       shadow_cycle;
  logic [31:0]                       shadow_iter;

  logic                              hs;
  logic                              start;
  logic                              accept;
  logic [31:0]                       word_next;
  logic [ADDRESS_WIDTH-1:0]          entry;
  logic [7:0]                        z8, x8, y8;

  assign hs    = out_valid & out_ready;
  assign start = result_valid & ~valid_d;

  // A new edge is taken in IDLE, or exactly as the last body word is accepted.
  assign accept = start & ((state == S_IDLE) |
                           ((state == S_BODY) & (idx == LAST_IDX) & hs));

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      S_IDLE: if (start) state_next = S_HDR0;
      S_HDR0: if (hs) state_next = S_HDR1;
      S_HDR1: if (hs) state_next = S_HDR2;
      S_HDR2: begin
        if (hs) begin
          state_next = S_BODY;
          idx_next   = '0;
        end
      end
      S_BODY: begin
        if (hs) begin
          if (idx == LAST_IDX) begin
            state_next = accept ? S_HDR0 : S_IDLE;
            idx_next   = '0;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Next output word is derived from the next state so every output stays registered.
  always_comb begin
    entry     = shadow_roots[int'(idx_next)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    z8        = '0;
    x8        = '0;
    y8        = '0;
    y8[PER_DIM_WIDTH-1:0] = entry[PER_DIM_WIDTH-1:0];
    x8[PER_DIM_WIDTH-1:0] = entry[2*PER_DIM_WIDTH-1:PER_DIM_WIDTH];
    z8[PER_DIM_WIDTH-1:0] = entry[3*PER_DIM_WIDTH-1:2*PER_DIM_WIDTH];
    word_next = '0;
    case (state_next)
      S_HDR0:  word_next = frame_id;
      S_HDR1:  word_next = shadow_cycle;
      S_HDR2:  word_next = shadow_iter;
      S_BODY:  word_next = {8'h00, z8, x8, y8};
      default: word_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      valid_d      <= 1'b0;
      frame_id     <= '0;
      shadow_roots <= '0;
      shadow_cycle <= '0;
      shadow_iter  <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      valid_d   <= result_valid;
      out_data  <= word_next;
      out_valid <= (state_next != S_IDLE);
      busy      <= (state_next != S_IDLE);
      out_last  <= (state_next == S_BODY) && (idx_next == LAST_IDX);
      if (accept) begin
        shadow_roots <= roots;
        shadow_cycle <= cycle_counter;
        shadow_iter  <= 32'(iteration_counter);
      end
      if (start && !accept) overrun <= 1'b1;
      if ((state == S_HDR0) && hs) frame_id <= frame_id + 32'd1;
    end
  end

endmodule

// File: tb/tb_root_stream_serializer.sv
// tb/tb_root_stream_serializer.sv - directed self-checking bench for root_stream_serializer
module tb_root_stream_serializer;

  localparam int PU = 100;
  localparam int AW = 9;
  localparam int NW = 103;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              result_valid = 1'b0;
  logic [AW*PU-1:0]  roots;
  logic [31:0]       cycle_counter;
  logic [7:0]        iteration_counter;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              overrun;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] got[$];
  int          last_cnt;
  int          last_pos;
  int          n_cycles;

  root_stream_serializer dut (
    .clk               (clk),
    .reset             (reset),
    .result_valid      (result_valid),
    .roots             (roots),
    .cycle_counter     (cycle_counter),
    .iteration_counter (iteration_counter),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_last          (out_last),
    .busy              (busy),
    .overrun           (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Pattern 0 is the decoder-index decomposition (k, i, j); pattern 1 is arbitrary.
  function automatic logic [23:0] zxy(input int seed, input int n);
    logic [7:0] z, x, y;
    if (seed == 0) begin
      z = 8'(n / 20);
      x = 8'((n / 4) % 5);
      y = 8'(n % 4);
    end else begin
      z = 8'((n + 1) % 7);
      x = 8'((n * 3) % 8);
      y = 8'(7 - (n % 8));
    end
    return {z, x, y};
  endfunction

  function automatic logic [AW*PU-1:0] mk_roots(input int seed);
    logic [AW*PU-1:0] r;
    logic [23:0]      v;
    r = '0;
    for (int n = 0; n < PU; n++) begin
      v = zxy(seed, n);
      r[n*AW +: AW] = {v[18:16], v[10:8], v[2:0]};
    end
    return r;
  endfunction

  task automatic send_edge();
    @(negedge clk);
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
  endtask

  task automatic collect(input bit rnd, input int poke_at, input bit b2b, input int abort_at);
    logic [31:0] prev_data;
    bit          prev_stall;
    bit          rdy;
    bit          poked;
    bit          done;
    int          cyc;
    prev_data  = '0;
    prev_stall = 1'b0;
    poked      = 1'b0;
    done       = 1'b0;
    cyc        = 0;
    got.delete();
    last_cnt = 0;
    last_pos = -1;
    while (!done && cyc < 2000) begin
      if (poked && result_valid) result_valid = 1'b0;
      if (poke_at >= 0 && !poked && got.size() == poke_at) begin
        result_valid = 1'b1;
        poked        = 1'b1;
      end
      if (abort_at >= 0 && got.size() == abort_at) begin
        reset = 1'b0;
        #1;
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        out_ready = 1'b0;
        return;
      end
      rdy       = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (prev_stall) begin
        check("stall_data", out_data, prev_data);
        check("stall_valid", out_valid, 1);
      end
      prev_stall = out_valid && !rdy;
      prev_data  = out_data;
      if (out_valid && rdy) begin
        got.push_back(out_data);
        if (out_last) begin
          last_cnt++;
          last_pos = got.size() - 1;
          done     = 1'b1;
          if (b2b) result_valid = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    n_cycles = cyc;
    if (!done) check("collect_timeout", 0, 1);
    if (b2b) result_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic check_frame(input logic [31:0] fid, input logic [31:0] cc, input logic [31:0] it, input int seed);
    check("frame_len", got.size(), NW);
    check("last_count", last_cnt, 1);
    check("last_pos", last_pos, NW - 1);
    if (got.size() == NW) begin
      check("hdr0_frame_id", got[0], fid);
      check("hdr1_cycle", got[1], cc);
      check("hdr2_iter", got[2], it);
      for (int n = 0; n < PU; n++)
        check($sformatf("body_%0d", n), got[3+n], {8'h00, zxy(seed, n)});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_valid;
    out_ready         = 1'b0;
    roots             = mk_roots(0);
    cycle_counter     = '0;
    iteration_counter = '0;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out_data", out_data, 32'h0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_last", out_last, 0);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_out_valid", out_valid, 0);

    // basic frame, ready held high
    cycle_counter     = 32'h123;
    iteration_counter = 8'd7;
    send_edge();
    check("lat_valid", out_valid, 1);
    check("lat_hdr0", out_data, 32'h0);
    collect(1'b0, -1, 1'b0, -1);
    check("basic_cycles", n_cycles, NW);
    check_frame(32'd0, 32'h123, 32'd7, 0);
    check("basic_busy_after", busy, 0);
    check("basic_valid_after", out_valid, 0);

    // backpressure, inputs altered one cycle after the edge
    roots             = mk_roots(0);
    cycle_counter     = 32'h0BAD_F00D;
    iteration_counter = 8'h5A;
    send_edge();
    roots             = mk_roots(1);
    cycle_counter     = 32'hDEAD_BEEF;
    iteration_counter = 8'h11;
    collect(1'b1, -1, 1'b0, -1);
    check_frame(32'd1, 32'h0BAD_F00D, 32'h5A, 0);

    // back-to-back: new edge on the cycle the last word is accepted
    roots             = mk_roots(0);
    cycle_counter     = 32'h200;
    iteration_counter = 8'd9;
    send_edge();
    roots             = mk_roots(1);
    cycle_counter     = 32'h300;
    iteration_counter = 8'hAB;
    collect(1'b1, -1, 1'b1, -1);
    check_frame(32'd2, 32'h200, 32'd9, 0);
    check("b2b_valid", out_valid, 1);
    check("b2b_hdr0", out_data, 32'd3);
    check("b2b_overrun", overrun, 0);
    collect(1'b0, -1, 1'b0, -1);
    check_frame(32'd3, 32'h300, 32'hAB, 1);

    // overrun: second edge during word 40
    roots             = mk_roots(0);
    cycle_counter     = 32'h400;
    iteration_counter = 8'h44;
    send_edge();
    collect(1'b0, 40, 1'b0, -1);
    check_frame(32'd4, 32'h400, 32'h44, 0);
    saw_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    out_ready = 1'b0;
    check("no_second_frame", saw_valid, 0);
    check("overrun_sticky", overrun, 1);

    // reset mid-frame at word 50, then a fresh frame
    send_edge();
    collect(1'b0, -1, 1'b0, 50);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    roots             = mk_roots(1);
    cycle_counter     = 32'h77;
    iteration_counter = 8'd3;
    send_edge();
    check("post_rst_hdr0", out_data, 32'h0);
    collect(1'b0, -1, 1'b0, -1);
    check_frame(32'd0, 32'h77, 32'd3, 1);
    check("post_rst_overrun", overrun, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
